pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Sequences the 5-stage MIPS pipeline around the main decoder and the stage registers.
- Detects load-use hazards and inserts ID/EX bubbles.
- Flushes wrong-path instructions on a taken branch resolved in MEM.
- Freezes the pipeline while data memory handshakes a variable-latency access.
- Holds a timeout FSM that parks the pipeline in a sticky error state if memory never answers.

Parameters:
- MEM_TIMEOUT, 255: maximum MEM_WAIT cycles before the error state; legal range 1..2^CNT_W-1.
- CNT_W, 8: width of the wait counter.
- REG_W, 5: register-specifier width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- id_rs  in  REG_W  rs field of the instruction in ID.
- id_rt  in  REG_W  rt field of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt (R-type, beq, sw).
- ex_rt  in  REG_W  destination rt of the instruction in EX.
- ex_mem_read  in  1  MemRead of the instruction in EX.
- mem_branch_taken  in  1  Branch & ALU zero of the instruction in MEM.
- dmem_req  in  1  MEM-stage instruction accesses memory (MemRead | memWrite).
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_write  out  1  PC load enable.
- pc_src  out  1  select branch target for the PC.
- if_id_write  out  1  IF/ID register enable.
- if_id_flush  out  1  clear IF/ID to a nop.
- id_ex_bubble  out  1  zero all control bits entering ID/EX.
- ex_mem_flush  out  1  clear EX/MEM control bits.
- pipe_hold  out  1  freeze ID/EX and EX/MEM.
- mem_wb_bubble  out  1  zero control bits entering MEM/WB.
- mem_timeout  out  1  sticky error flag.
- stall_cycles  out  32  performance count of stalled cycles (feature-dependent).
- flush_count  out  32  performance count of taken-branch flushes (feature-dependent).

Behaviour:

States: RUN, MEM_WAIT, ERROR. The state register and wait counter are the only core registers. Outputs are combinational from state and inputs.

Reset (reset=1 at a clk edge):
- State goes to RUN, wait counter to 0, mem_timeout to 0, performance counters to 0.
- While reset is high, outputs are forced: pc_write=0, if_id_write=0, pc_src=0, pipe_hold=1, if_id_flush=1, id_ex_bubble=1, ex_mem_flush=1, mem_wb_bubble=1.
- Reset asserted mid-wait or in ERROR returns to RUN on the next edge.

Defaults in RUN with no hazard:
- pc_write=1, if_id_write=1.
- All flush/bubble/hold outputs 0, pc_src=0.

Priority within RUN: memory wait > taken branch > load-use.

Memory wait:
- Condition: dmem_req=1 and dmem_ready=0.
- Same cycle: pc_write=0, if_id_write=0, pipe_hold=1, mem_wb_bubble=1.
- Next state MEM_WAIT, counter loads 1.
- MEM_WAIT holds the same outputs each cycle and increments the counter.
- When dmem_ready=1: outputs revert to RUN defaults that cycle (the MEM instruction advances), state goes to RUN, counter clears.
- If the counter equals MEM_TIMEOUT and dmem_ready=0: go to ERROR and set mem_timeout=1.
- A zero-latency access (dmem_req=1 and dmem_ready=1 in RUN) causes no stall.

Taken branch:
- Condition: mem_branch_taken=1, no memory wait.
- Single cycle: pc_src=1, pc_write=1, if_id_flush=1, id_ex_bubble=1, ex_mem_flush=1.
- State stays RUN; penalty is 3 cycles.
- Any simultaneous load-use hazard is discarded (its instruction is flushed).
- mem_branch_taken is ignored while pipe_hold=1.

Load-use hazard:
- Condition: ex_mem_read=1, ex_rt≠0, and (ex_rt==id_rs or (id_uses_rt and ex_rt==id_rt)).
- Response: pc_write=0, if_id_write=0, id_ex_bubble=1.
- Exactly one bubble per load, since the load leaves EX next cycle.
- Register 0 never causes a stall.

ERROR:
- pc_write=0, if_id_write=0, pipe_hold=1, mem_wb_bubble=1, mem_timeout=1.
- Held until reset; all inputs ignored.

Optional Feature:

Macro: HAZARD_PERF_EN.

Defined:
- stall_cycles increments every cycle with pc_write=0 outside reset (load-use, MEM_WAIT, ERROR).
- flush_count increments on every taken-branch cycle.
- Both are 32-bit and wrap modulo 2^32.
- Both clear on reset.

Undefined:
- No counter registers are built; both outputs are tied to 0.

Test Plan:
1. Load-use: lw writes $8 in EX (ex_mem_read=1, ex_rt=8), ID add reads rs=8 -> one cycle with pc_write=0, if_id_write=0, id_ex_bubble=1; the next cycle returns to defaults. Repeat with ex_rt=0 -> no stall.
2. rt-only hazard: ex_rt=9 and id_rt=9 with id_uses_rt=0 -> no stall; with id_uses_rt=1 -> one bubble.
3. Taken branch with a simultaneous load-use condition -> a single cycle of pc_src=1, if_id_flush=1, id_ex_bubble=1, ex_mem_flush=1, pc_write=1. With HAZARD_PERF_EN: flush_count=1, stall_cycles=0.
4. Memory wait: dmem_req=1, dmem_ready low for 4 cycles then high -> pipe_hold=1 for 4 cycles and released in the ready cycle. A branch asserted during the wait is ignored. stall_cycles=4.
5. Timeout with MEM_TIMEOUT=3: dmem_ready held low -> mem_timeout=1 after the third wait cycle and the pipeline stays frozen. Pulsing reset -> RUN, mem_timeout=0, counters 0.
6. Reset mid-MEM_WAIT -> all forced reset outputs while reset=1, then RUN defaults on the first post-reset cycle.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing control for the 5-stage MIPS pipeline: load-use bubbles,
// taken-branch flushes, data-memory wait freeze and timeout. Optional perf counters: HAZARD_PERF_EN.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 8,
    parameter int REG_W       = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             ex_mem_read,
    input  logic             mem_branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             pc_src,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             ex_mem_flush,
    output logic             pipe_hold,
    output logic             mem_wb_bubble,
    output logic             mem_timeout,
    output logic [31:0]      stall_cycles,
    output logic [31:0]      flush_count
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

    state_t           state, next_state;
    logic [CNT_W-1:0] wait_cnt, next_cnt;
    logic             load_use;
    logic             mem_stall;

    assign load_use = ex_mem_read && (ex_rt != '0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    // Once waiting, only dmem_ready releases the freeze; dmem_req matters only on entry.
    assign mem_stall = (state == MEM_WAIT) ? !dmem_ready
                                           : ((state == RUN) && dmem_req && !dmem_ready);

    assign mem_timeout = (state == ERROR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= next_state;
            wait_cnt <= next_cnt;
        end
    end

    always_comb begin
        next_state    = state;
        next_cnt      = wait_cnt;
        pc_write      = 1'b1;
        pc_src        = 1'b0;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_mem_flush  = 1'b0;
        pipe_hold     = 1'b0;
        mem_wb_bubble = 1'b0;
        if (reset) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            pipe_hold     = 1'b1;
            if_id_flush   = 1'b1;
            id_ex_bubble  = 1'b1;
            ex_mem_flush  = 1'b1;
            mem_wb_bubble = 1'b1;
        end else if (state == ERROR || mem_stall) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            pipe_hold     = 1'b1;
            mem_wb_bubble = 1'b1;
            if (state == RUN) begin
                next_state = MEM_WAIT;
                next_cnt   = CNT_W'(1);
            end else if (state == MEM_WAIT) begin
                if (wait_cnt == TIMEOUT_CNT) begin
                    next_state = ERROR;
                end else begin
                    next_cnt = wait_cnt + CNT_W'(1);
                end
            end
        end else begin
            // The access (if any) completes this cycle; normal RUN priorities apply.
            next_state = RUN;
            next_cnt   = '0;
            if (mem_branch_taken) begin
                pc_src       = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
                ex_mem_flush = 1'b1;
            end else if (load_use) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_q;
    logic [31:0] flush_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_write) stall_q <= stall_q + 32'd1;
            if (pc_src)    flush_q <= flush_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    assign stall_cycles = 32'd0;
    assign flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: decode table, multi-cycle wait/timeout/reset
// sequences and randomized traffic, on a default instance and a MEM_TIMEOUT=3 instance.
module tb_pipeline_hazard_ctrl;

    // Output vector order: {pc_write, pc_src, if_id_write, if_id_flush,
    // id_ex_bubble, ex_mem_flush, pipe_hold, mem_wb_bubble, mem_timeout}
    localparam logic [8:0] O_DEF  = 9'b101000000;
    localparam logic [8:0] O_LU   = 9'b000010000;
    localparam logic [8:0] O_BR   = 9'b111111000;
    localparam logic [8:0] O_WAIT = 9'b000000110;
    localparam logic [8:0] O_ERR  = 9'b000000111;

`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
    logic       id_uses_rt = 1'b0, ex_mem_read = 1'b0, mem_branch_taken = 1'b0;
    logic       dmem_req = 1'b0, dmem_ready = 1'b0;

    logic [8:0]  out0, out1;
    logic [31:0] stall0, flush0, stall1, flush1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl dut (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_rt(ex_rt), .ex_mem_read(ex_mem_read), .mem_branch_taken(mem_branch_taken),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write(out0[8]), .pc_src(out0[7]), .if_id_write(out0[6]), .if_id_flush(out0[5]),
        .id_ex_bubble(out0[4]), .ex_mem_flush(out0[3]), .pipe_hold(out0[2]),
        .mem_wb_bubble(out0[1]), .mem_timeout(out0[0]),
        .stall_cycles(stall0), .flush_count(flush0)
    );

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(3)) dut_to (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_rt(ex_rt), .ex_mem_read(ex_mem_read), .mem_branch_taken(mem_branch_taken),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write(out1[8]), .pc_src(out1[7]), .if_id_write(out1[6]), .if_id_flush(out1[5]),
        .id_ex_bubble(out1[4]), .ex_mem_flush(out1[3]), .pipe_hold(out1[2]),
        .mem_wb_bubble(out1[1]), .mem_timeout(out1[0]),
        .stall_cycles(stall1), .flush_count(flush1)
    );

    // Reference model: per instance, consecutive unanswered wait cycles and a sticky error.
    int          m_to[2] = '{255, 3};
    int          m_wc[2] = '{0, 0};
    bit          m_err[2] = '{1'b0, 1'b0};
    logic [31:0] m_stall[2] = '{32'd0, 32'd0};
    logic [31:0] m_flush[2] = '{32'd0, 32'd0};

    function automatic bit model_mem_stall(int k);
        if (m_err[k]) return 1'b1;
        if (m_wc[k] > 0) return !dmem_ready;
        return dmem_req && !dmem_ready;
    endfunction

    function automatic logic [8:0] model_out(int k);
        bit lu;
        lu = ex_mem_read && (ex_rt != 0) &&
             ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
        if (reset)              return {8'b00011111, m_err[k]};
        if (model_mem_stall(k)) return m_err[k] ? O_ERR : O_WAIT;
        if (mem_branch_taken)   return O_BR;
        if (lu)                 return O_LU;
        return O_DEF;
    endfunction

    function automatic void model_update(int k, logic [8:0] o);
        bit ms;
        ms = model_mem_stall(k);
        if (reset) begin
            m_err[k] = 1'b0; m_wc[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
        end else begin
            if (!o[8]) m_stall[k] = m_stall[k] + 32'd1;
            if (o[7])  m_flush[k] = m_flush[k] + 32'd1;
            if (!m_err[k]) begin
                if (ms) begin
                    m_wc[k] = m_wc[k] + 1;
                    if (m_wc[k] > m_to[k]) m_err[k] = 1'b1;
                end else begin
                    m_wc[k] = 0;
                end
            end
        end
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Inputs are already driven; sample before the edge, clock once, check counters after.
    task automatic run_cycle(output logic [8:0] s0, output logic [8:0] s1);
        logic [8:0] e0, e1;
        #2;
        e0 = model_out(0);
        e1 = model_out(1);
        s0 = out0;
        s1 = out1;
        check("outputs_dut", out0, e0);
        check("outputs_dut_to", out1, e1);
        @(posedge clk);
        model_update(0, e0);
        model_update(1, e1);
        #1;
        check("stall_cycles_dut", stall0, PERF ? m_stall[0] : 32'd0);
        check("flush_count_dut", flush0, PERF ? m_flush[0] : 32'd0);
        check("stall_cycles_dut_to", stall1, PERF ? m_stall[1] : 32'd0);
        check("flush_count_dut_to", flush1, PERF ? m_flush[1] : 32'd0);
    endtask

    task automatic clear_inputs();
        id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; ex_rt = '0; ex_mem_read = 1'b0;
        mem_branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic do_reset();
        logic [8:0] s0, s1;
        clear_inputs();
        reset = 1'b1;
        run_cycle(s0, s1);
        check("reset_forced_outputs", s0[8:1], 8'b00011111);
        reset = 1'b0;
    endtask

    typedef struct {
        logic [4:0] rs, rt;
        logic       uses_rt;
        logic [4:0] ert;
        logic       emr, br, req, rdy;
        logic [8:0] exp;
    } vec_t;

    initial begin
        vec_t       vecs[12];
        logic [8:0] s0, s1;

        // rs, rt, uses_rt, ex_rt, ex_mem_read, branch, req, ready, expected
        vecs[0]  = '{5'd8,  5'd3, 1'b1, 5'd8,  1'b1, 1'b0, 1'b0, 1'b0, O_LU};
        vecs[1]  = '{5'd8,  5'd3, 1'b1, 5'd4,  1'b0, 1'b0, 1'b0, 1'b0, O_DEF};
        vecs[2]  = '{5'd0,  5'd3, 1'b1, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, O_DEF};
        vecs[3]  = '{5'd1,  5'd9, 1'b0, 5'd9,  1'b1, 1'b0, 1'b0, 1'b0, O_DEF};
        vecs[4]  = '{5'd1,  5'd9, 1'b1, 5'd9,  1'b1, 1'b0, 1'b0, 1'b0, O_LU};
        vecs[5]  = '{5'd8,  5'd3, 1'b1, 5'd8,  1'b0, 1'b0, 1'b0, 1'b0, O_DEF};
        vecs[6]  = '{5'd8,  5'd3, 1'b1, 5'd8,  1'b1, 1'b1, 1'b0, 1'b0, O_BR};
        vecs[7]  = '{5'd2,  5'd3, 1'b1, 5'd7,  1'b0, 1'b0, 1'b1, 1'b1, O_DEF};
        vecs[8]  = '{5'd7,  5'd3, 1'b0, 5'd7,  1'b1, 1'b0, 1'b1, 1'b1, O_LU};
        vecs[9]  = '{5'd2,  5'd3, 1'b1, 5'd7,  1'b0, 1'b1, 1'b1, 1'b1, O_BR};
        vecs[10] = '{5'd31, 5'd0, 1'b0, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, O_LU};
        vecs[11] = '{5'd0,  5'd0, 1'b1, 5'd0,  1'b1, 1'b0, 1'b0, 1'b1, O_DEF};

        @(posedge clk);
        #1;
        do_reset();

        // Branch with simultaneous load-use, counters from a fresh reset.
        id_rs = 5'd8; ex_rt = 5'd8; ex_mem_read = 1'b1; mem_branch_taken = 1'b1;
        run_cycle(s0, s1);
        check("branch_over_loaduse", s0, O_BR);
        check("branch_flush_count", flush0, PERF ? 32'd1 : 32'd0);
        check("branch_stall_cycles", stall0, 32'd0);
        clear_inputs();

        for (int i = 0; i < 12; i++) begin
            id_rs = vecs[i].rs; id_rt = vecs[i].rt; id_uses_rt = vecs[i].uses_rt;
            ex_rt = vecs[i].ert; ex_mem_read = vecs[i].emr; mem_branch_taken = vecs[i].br;
            dmem_req = vecs[i].req; dmem_ready = vecs[i].rdy;
            run_cycle(s0, s1);
            check($sformatf("table_vec_%0d", i), s0, vecs[i].exp);
        end

        // Memory wait: four unanswered cycles, branch ignored mid-wait, release on ready.
        do_reset();
        dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_branch_taken = (i == 2);
            run_cycle(s0, s1);
            check($sformatf("wait_hold_%0d", i), s0, O_WAIT);
        end
        mem_branch_taken = 1'b0; dmem_ready = 1'b1;
        run_cycle(s0, s1);
        check("wait_release", s0, O_DEF);
        check("wait_stall_cycles", stall0, PERF ? 32'd4 : 32'd0);
        clear_inputs();
        run_cycle(s0, s1);
        check("after_wait_default", s0, O_DEF);

        // Timeout on the MEM_TIMEOUT=3 instance.
        do_reset();
        dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            run_cycle(s0, s1);
            check($sformatf("timeout_flag_%0d", i), out1[0], (i == 3) ? 1'b1 : 1'b0);
        end
        dmem_ready = 1'b1; mem_branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            run_cycle(s0, s1);
            check($sformatf("error_frozen_%0d", i), s1, O_ERR);
        end
        do_reset();
        check("timeout_cleared", out1[0], 1'b0);
        check("timeout_stall_cleared", stall1, 32'd0);

        // Reset in the middle of a wait.
        dmem_req = 1'b1; dmem_ready = 1'b0;
        run_cycle(s0, s1);
        run_cycle(s0, s1);
        reset = 1'b1;
        run_cycle(s0, s1);
        check("midwait_reset_forced", s0[8:1], 8'b00011111);
        reset = 1'b0;
        clear_inputs();
        run_cycle(s0, s1);
        check("post_reset_default", s0, O_DEF);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            reset            = ($urandom_range(0, 79) == 0);
            id_rs            = 5'($urandom_range(0, 3));
            id_rt            = 5'($urandom_range(0, 3));
            id_uses_rt       = 1'($urandom_range(0, 1));
            ex_rt            = 5'($urandom_range(0, 3));
            ex_mem_read      = 1'($urandom_range(0, 1));
            mem_branch_taken = ($urandom_range(0, 5) == 0);
            dmem_req         = ($urandom_range(0, 3) == 0);
            dmem_ready       = ($urandom_range(0, 2) == 0);
            run_cycle(s0, s1);
        end
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
